// File: rtl/pipelined_control_if.sv
// ID-stage control handshake between front end and the control pipeline.
// Carries decode inputs, flush/stall controls and per-stage control outputs.
interface pipelined_control_if #(
  parameter int ALUOP_W = 2,
  parameter int CNT_W   = 16
);
  logic               valid_i;
  logic [6:0]         op_i;
  logic [4:0]         rs1_i;
  logic [4:0]         rs2_i;
  logic [4:0]         rd_i;
  logic               flush_i;
  logic               stall_i;
  logic               stall_o;
  logic [ALUOP_W-1:0] ex_alu_op_o;
  logic               ex_alu_src_o;
  logic               ex_branch_o;
  logic               ex_jump_o;
  logic               ex_illegal_o;
  logic [4:0]         ex_rd_o;
  logic               mem_mem_read_o;
  logic               mem_mem_write_o;
  logic               mem_reg_write_o;
  logic [4:0]         mem_rd_o;
  logic               wb_reg_write_o;
  logic               wb_mem_to_reg_o;
  logic [4:0]         wb_rd_o;
  logic [CNT_W-1:0]   bubble_cnt_o;

  modport master (
    output valid_i, op_i, rs1_i, rs2_i, rd_i,
    output flush_i, stall_i,
    input  stall_o,
    input  ex_alu_op_o, ex_alu_src_o, ex_branch_o,
    input  ex_jump_o, ex_illegal_o, ex_rd_o,
    input  mem_mem_read_o, mem_mem_write_o,
    input  mem_reg_write_o, mem_rd_o,
    input  wb_reg_write_o, wb_mem_to_reg_o, wb_rd_o,
    input  bubble_cnt_o
  );

  modport slave (
    input  valid_i, op_i, rs1_i, rs2_i, rd_i,
    input  flush_i, stall_i,
    output stall_o,
    output ex_alu_op_o, ex_alu_src_o, ex_branch_o,
    output ex_jump_o, ex_illegal_o, ex_rd_o,
    output mem_mem_read_o, mem_mem_write_o,
    output mem_reg_write_o, mem_rd_o,
    output wb_reg_write_o, wb_mem_to_reg_o, wb_rd_o,
    output bubble_cnt_o
  );
endinterface

// File: rtl/pipelined_control.sv
// Control path for the 5-stage pipeline: ID decode, ID/EX, EX/MEM, MEM/WB
// control registers, load-use stall detection and a bubble counter.
module pipelined_control #(
  parameter int ALUOP_W    = 2,
  parameter bit ENABLE_JAL = 1'b1,
  parameter bit HAZARD_EN  = 1'b1,
  parameter int CNT_W      = 16
) (
  input logic               clk_i,
  input logic               rst_i,
  pipelined_control_if.slave bus
);

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [ALUOP_W-1:0] ALU_ADD = ALUOP_W'(2'b00);
  localparam logic [ALUOP_W-1:0] ALU_BR  = ALUOP_W'(2'b01);
  localparam logic [ALUOP_W-1:0] ALU_R   = ALUOP_W'(2'b10);
  localparam logic [ALUOP_W-1:0] ALU_I   = ALUOP_W'(2'b11);

  typedef struct packed {
    logic               regWrite;
    logic               memToReg;
    logic               memRead;
    logic               memWrite;
    logic [ALUOP_W-1:0] aluOp;
    logic               aluSrc;
    logic               branch;
    logic               jump;
    logic               illegal;
    logic [4:0]         rd;
  } id_ex_t;

  typedef struct packed {
    logic       regWrite;
    logic       memToReg;
    logic       memRead;
    logic       memWrite;
    logic [4:0] rd;
  } ex_mem_t;

  typedef struct packed {
    logic       regWrite;
    logic       memToReg;
    logic [4:0] rd;
  } mem_wb_t;

  id_ex_t           dec;
  id_ex_t           idEx;
  ex_mem_t          exMem;
  mem_wb_t          memWb;
  logic             useRs1;
  logic             useRs2;
  logic             stallReq;
  logic             loadBubble;
  logic [CNT_W-1:0] bubbleCnt;

  logic isR;
  logic isI;
  logic isLw;
  logic isSw;
  logic isBeq;
  logic isJal;

  assign isR   = bus.valid_i && (bus.op_i == OP_R);
  assign isI   = bus.valid_i && (bus.op_i == OP_I);
  assign isLw  = bus.valid_i && (bus.op_i == OP_LW);
  assign isSw  = bus.valid_i && (bus.op_i == OP_SW);
  assign isBeq = bus.valid_i && (bus.op_i == OP_BEQ);
  assign isJal = ENABLE_JAL && bus.valid_i
              && (bus.op_i == OP_JAL);

  // ID-stage decode into the control bundle plus source-use flags
  always_comb begin
    dec    = '0;
    useRs1 = 1'b0;
    useRs2 = 1'b0;
    unique case (1'b1)
      isR: begin
        dec.regWrite = 1'b1;
        dec.aluOp    = ALU_R;
        dec.rd       = bus.rd_i;
        useRs1       = 1'b1;
        useRs2       = 1'b1;
      end
      isI: begin
        dec.regWrite = 1'b1;
        dec.aluOp    = ALU_I;
        dec.aluSrc   = 1'b1;
        dec.rd       = bus.rd_i;
        useRs1       = 1'b1;
      end
      isLw: begin
        dec.regWrite = 1'b1;
        dec.memToReg = 1'b1;
        dec.memRead  = 1'b1;
        dec.aluOp    = ALU_ADD;
        dec.aluSrc   = 1'b1;
        dec.rd       = bus.rd_i;
        useRs1       = 1'b1;
      end
      isSw: begin
        dec.memWrite = 1'b1;
        dec.aluOp    = ALU_ADD;
        dec.aluSrc   = 1'b1;
        dec.rd       = bus.rd_i;
        useRs1       = 1'b1;
        useRs2       = 1'b1;
      end
      isBeq: begin
        dec.aluOp    = ALU_BR;
        dec.branch   = 1'b1;
        dec.rd       = bus.rd_i;
        useRs1       = 1'b1;
        useRs2       = 1'b1;
      end
      isJal: begin
        dec.regWrite = 1'b1;
        dec.jump     = 1'b1;
        dec.rd       = bus.rd_i;
      end
      default: begin
        dec.illegal  = bus.valid_i;
      end
    endcase
  end

  // Load-use hazard: a load in EX whose rd feeds a source used in ID
  always_comb begin
    stallReq = 1'b0;
    if (HAZARD_EN && bus.valid_i
        && idEx.memRead && (idEx.rd != 5'd0)) begin
      stallReq = (useRs1 && (bus.rs1_i == idEx.rd))
              || (useRs2 && (bus.rs2_i == idEx.rd));
    end
  end

  assign loadBubble = !bus.stall_i
                   && (bus.flush_i || stallReq);

  // ID/EX register: hold on freeze, bubble on flush/load-use, else load
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      idEx <= '0;
    end else if (bus.stall_i) begin
      idEx <= idEx;
    end else if (loadBubble) begin
      idEx <= '0;
    end else begin
      idEx <= dec;
    end
  end

  // EX/MEM register: shifts from ID/EX unless frozen
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      exMem <= '0;
    end else if (!bus.stall_i) begin
      exMem.regWrite <= idEx.regWrite;
      exMem.memToReg <= idEx.memToReg;
      exMem.memRead  <= idEx.memRead;
      exMem.memWrite <= idEx.memWrite;
      exMem.rd       <= idEx.rd;
    end
  end

  // MEM/WB register: shifts from EX/MEM unless frozen
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      memWb <= '0;
    end else if (!bus.stall_i) begin
      memWb.regWrite <= exMem.regWrite;
      memWb.memToReg <= exMem.memToReg;
      memWb.rd       <= exMem.rd;
    end
  end

  // Saturating count of bubbles loaded into ID/EX
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bubbleCnt <= '0;
    end else if (loadBubble && (bubbleCnt != '1)) begin
      bubbleCnt <= bubbleCnt + CNT_W'(1);
    end
  end

  assign bus.stall_o         = stallReq;
  assign bus.ex_alu_op_o     = idEx.aluOp;
  assign bus.ex_alu_src_o    = idEx.aluSrc;
  assign bus.ex_branch_o     = idEx.branch;
  assign bus.ex_jump_o       = idEx.jump;
  assign bus.ex_illegal_o    = idEx.illegal;
  assign bus.ex_rd_o         = idEx.rd;
  assign bus.mem_mem_read_o  = exMem.memRead;
  assign bus.mem_mem_write_o = exMem.memWrite;
  assign bus.mem_reg_write_o = exMem.regWrite;
  assign bus.mem_rd_o        = exMem.rd;
  assign bus.wb_reg_write_o  = memWb.regWrite;
  assign bus.wb_mem_to_reg_o = memWb.memToReg;
  assign bus.wb_rd_o         = memWb.rd;
  assign bus.bubble_cnt_o    = bubbleCnt;

endmodule

// File: tb/tb_pipelined_control.sv
// Scoreboard bench for pipelined_control: two instances (default and
// CNT_W=2 / no JAL) driven with directed and random ID-stage traffic.
module tb_pipelined_control;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipelined_control_if #(.ALUOP_W(2), .CNT_W(16)) bus0 ();
  pipelined_control_if #(.ALUOP_W(2), .CNT_W(2))  bus1 ();

  pipelined_control #(
    .ALUOP_W(2), .ENABLE_JAL(1'b1),
    .HAZARD_EN(1'b1), .CNT_W(16)
  ) dut0 (.clk_i(clk), .rst_i(rst), .bus(bus0));

  pipelined_control #(
    .ALUOP_W(2), .ENABLE_JAL(1'b0),
    .HAZARD_EN(1'b1), .CNT_W(2)
  ) dut1 (.clk_i(clk), .rst_i(rst), .bus(bus1));

  localparam logic [6:0] R   = 7'b0110011;
  localparam logic [6:0] I   = 7'b0010011;
  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] BEQ = 7'b1100011;
  localparam logic [6:0] JAL = 7'b1101111;
  localparam logic [6:0] BAD = 7'b1111111;

  typedef struct packed {
    logic       rw;
    logic       mtr;
    logic       mr;
    logic       mw;
    logic [1:0] aop;
    logic       as;
    logic       br;
    logic       jp;
    logic       ill;
    logic [4:0] rd;
  } ent_t;

  typedef struct {
    logic stall;
    ent_t ex;
    ent_t mem;
    ent_t wb;
    int   cnt;
  } exp_t;

  ent_t hist [2][$];
  int   bub  [2];
  exp_t sb   [2][$];
  int   checks   = 0;
  int   failures = 0;

  function automatic ent_t decodeRef(bit v, logic [6:0] op,
                                     logic [4:0] rd, bit enJal);
    logic [8:0] f;
    ent_t e;
    e = '0;
    if (!v) return e;
    case (op)
      R:   f = 9'b1000_10_000;
      I:   f = 9'b1000_11_100;
      LW:  f = 9'b1110_00_100;
      SW:  f = 9'b0001_00_100;
      BEQ: f = 9'b0000_01_010;
      JAL: f = enJal ? 9'b1000_00_001 : 9'h1ff;
      default: f = 9'h1ff;
    endcase
    if (f == 9'h1ff) begin
      e.ill = 1'b1;
      return e;
    end
    e = {f, 1'b0, rd};
    return e;
  endfunction

  function automatic bit readsRs1(logic [6:0] op);
    return op == R || op == I || op == LW
        || op == SW || op == BEQ;
  endfunction

  function automatic bit readsRs2(logic [6:0] op);
    return op == R || op == SW || op == BEQ;
  endfunction

  task automatic chk(string nm, int k,
                     logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s dut%0d t=%0t actual=%0h required=%0h",
               nm, k, $time, act, exp);
    end
  endtask

  task automatic step(bit r, bit v, logic [6:0] op,
                      logic [4:0] a, logic [4:0] b, logic [4:0] d,
                      bit fl, bit st);
    ent_t ex;
    exp_t e;
    bit   hz;
    int   cmax;
    @(posedge clk);
    #1;
    rst = r;
    bus0.valid_i = v; bus1.valid_i = v;
    bus0.op_i    = op; bus1.op_i    = op;
    bus0.rs1_i   = a;  bus1.rs1_i   = a;
    bus0.rs2_i   = b;  bus1.rs2_i   = b;
    bus0.rd_i    = d;  bus1.rd_i    = d;
    bus0.flush_i = fl; bus1.flush_i = fl;
    bus0.stall_i = st; bus1.stall_i = st;
    for (int k = 0; k < 2; k++) begin
      cmax = (k == 0) ? 65535 : 3;
      ex = hist[k][2];
      hz = v && ex.mr && ex.rd != 0
        && ((readsRs1(op) && a == ex.rd)
         || (readsRs2(op) && b == ex.rd));
      e.stall = hz;
      e.ex    = hist[k][2];
      e.mem   = hist[k][1];
      e.wb    = hist[k][0];
      e.cnt   = (bub[k] > cmax) ? cmax : bub[k];
      sb[k].push_back(e);
      if (r) begin
        hist[k] = '{ent_t'(0), ent_t'(0), ent_t'(0)};
        bub[k] = 0;
      end else if (!st) begin
        if (fl || hz) begin
          hist[k].push_back(ent_t'(0));
          bub[k]++;
        end else begin
          hist[k].push_back(decodeRef(v, op, d, k == 0));
        end
        void'(hist[k].pop_front());
      end
    end
  endtask

  task automatic nop(int n);
    for (int i = 0; i < n; i++) step(0, 0, 7'd0, 0, 0, 0, 0, 0);
  endtask

  function automatic exp_t snap(int k);
    exp_t s;
    s = '{default: '0};
    if (k == 0) begin
      s.stall = bus0.stall_o;
      s.ex.aop = bus0.ex_alu_op_o;  s.ex.as = bus0.ex_alu_src_o;
      s.ex.br  = bus0.ex_branch_o;  s.ex.jp = bus0.ex_jump_o;
      s.ex.ill = bus0.ex_illegal_o; s.ex.rd = bus0.ex_rd_o;
      s.mem.mr = bus0.mem_mem_read_o;  s.mem.mw = bus0.mem_mem_write_o;
      s.mem.rw = bus0.mem_reg_write_o; s.mem.rd = bus0.mem_rd_o;
      s.wb.rw  = bus0.wb_reg_write_o;  s.wb.mtr = bus0.wb_mem_to_reg_o;
      s.wb.rd  = bus0.wb_rd_o;
      s.cnt    = int'(bus0.bubble_cnt_o);
    end else begin
      s.stall = bus1.stall_o;
      s.ex.aop = bus1.ex_alu_op_o;  s.ex.as = bus1.ex_alu_src_o;
      s.ex.br  = bus1.ex_branch_o;  s.ex.jp = bus1.ex_jump_o;
      s.ex.ill = bus1.ex_illegal_o; s.ex.rd = bus1.ex_rd_o;
      s.mem.mr = bus1.mem_mem_read_o;  s.mem.mw = bus1.mem_mem_write_o;
      s.mem.rw = bus1.mem_reg_write_o; s.mem.rd = bus1.mem_rd_o;
      s.wb.rw  = bus1.wb_reg_write_o;  s.wb.mtr = bus1.wb_mem_to_reg_o;
      s.wb.rd  = bus1.wb_rd_o;
      s.cnt    = int'(bus1.bubble_cnt_o);
    end
    return s;
  endfunction

  // monitor: pop the expected picture and compare on the falling edge
  initial begin
    exp_t e;
    exp_t a;
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (sb[k].size() > 0) begin
          e = sb[k].pop_front();
          a = snap(k);
          chk("stall_o",     k, 32'(a.stall),  32'(e.stall));
          chk("ex_alu_op",   k, 32'(a.ex.aop), 32'(e.ex.aop));
          chk("ex_alu_src",  k, 32'(a.ex.as),  32'(e.ex.as));
          chk("ex_branch",   k, 32'(a.ex.br),  32'(e.ex.br));
          chk("ex_jump",     k, 32'(a.ex.jp),  32'(e.ex.jp));
          chk("ex_illegal",  k, 32'(a.ex.ill), 32'(e.ex.ill));
          chk("ex_rd",       k, 32'(a.ex.rd),  32'(e.ex.rd));
          chk("mem_read",    k, 32'(a.mem.mr), 32'(e.mem.mr));
          chk("mem_write",   k, 32'(a.mem.mw), 32'(e.mem.mw));
          chk("mem_regwr",   k, 32'(a.mem.rw), 32'(e.mem.rw));
          chk("mem_rd",      k, 32'(a.mem.rd), 32'(e.mem.rd));
          chk("wb_regwr",    k, 32'(a.wb.rw),  32'(e.wb.rw));
          chk("wb_memtoreg", k, 32'(a.wb.mtr), 32'(e.wb.mtr));
          chk("wb_rd",       k, 32'(a.wb.rd),  32'(e.wb.rd));
          chk("bubble_cnt",  k, 32'(a.cnt),    32'(e.cnt));
        end
      end
    end
  end

  initial begin
    logic [6:0] opTab [8];
    logic [6:0] op;
    opTab = '{R, I, LW, SW, BEQ, JAL, BAD, 7'd0};
    for (int k = 0; k < 2; k++) begin
      hist[k] = '{ent_t'(0), ent_t'(0), ent_t'(0)};
      bub[k]  = 0;
    end
    bus0.valid_i = 0; bus1.valid_i = 0;
    bus0.op_i = 0;    bus1.op_i = 0;
    bus0.rs1_i = 0;   bus1.rs1_i = 0;
    bus0.rs2_i = 0;   bus1.rs2_i = 0;
    bus0.rd_i = 0;    bus1.rd_i = 0;
    bus0.flush_i = 0; bus1.flush_i = 0;
    bus0.stall_i = 0; bus1.stall_i = 0;
    rst = 1'b1;
    repeat (2) @(posedge clk);

    // R-type rd=5 flowing through EX, MEM, WB
    step(0, 1, R, 1, 2, 5, 0, 0);
    nop(3);
    // lw x3 then add using x3: one load-use bubble, add held one cycle
    step(0, 1, LW, 1, 0, 3, 0, 0);
    step(0, 1, R, 3, 0, 6, 0, 0);
    step(0, 1, R, 3, 0, 6, 0, 0);
    nop(3);
    // x0 never hazards; jal ignores its rs1 field
    step(0, 1, LW, 1, 0, 0, 0, 0);
    step(0, 1, R, 0, 0, 7, 0, 0);
    step(0, 1, LW, 1, 0, 4, 0, 0);
    step(0, 1, JAL, 4, 0, 1, 0, 0);
    nop(3);
    // beq, then flush under freeze for two cycles, then release
    step(0, 1, BEQ, 1, 2, 0, 0, 0);
    step(0, 0, 7'd0, 0, 0, 0, 1, 1);
    step(0, 0, 7'd0, 0, 0, 0, 1, 1);
    step(0, 0, 7'd0, 0, 0, 0, 1, 0);
    nop(3);
    // illegal opcode valid / not valid, jal on the no-JAL instance
    step(0, 1, BAD, 1, 2, 9, 0, 0);
    step(0, 0, BAD, 1, 2, 9, 0, 0);
    step(0, 1, JAL, 0, 0, 2, 0, 0);
    nop(3);
    // counter saturation on the 2-bit instance, then mid-run reset
    step(1, 0, 7'd0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 1, R, 1, 1, 1, 1, 0);
    step(0, 1, LW, 1, 0, 2, 0, 0);
    step(0, 1, R, 2, 2, 3, 0, 0);
    step(1, 1, R, 2, 2, 3, 0, 0);
    nop(2);

    // random traffic over a small register set to provoke hazards
    for (int i = 0; i < 600; i++) begin
      op = opTab[$urandom_range(0, 7)];
      if (op == 7'd0) op = 7'($urandom);
      step(($urandom_range(0, 99) < 2),
           ($urandom_range(0, 99) < 85),
           op,
           5'($urandom_range(0, 3)),
           5'($urandom_range(0, 3)),
           5'($urandom_range(0, 3)),
           ($urandom_range(0, 99) < 12),
           ($urandom_range(0, 99) < 12));
    end
    nop(2);

    repeat (4) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("scoreboard_drained", k, 32'(sb[k].size()), 32'd0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipelined_control.md
Name: pipelined_control

Overview:
- Control-path successor block for the 5-stage RISC-V pipeline.
- Decodes the ID-stage opcode into a control bundle and carries it through ID/EX, EX/MEM and MEM/WB registers, with per-cycle stall, flush and bubble insertion.
- Detects load-use hazards internally and raises a stall to the front end.
- Keeps a saturating bubble counter for performance debug.
- Sits between the IF/ID register and the datapath stage registers; its per-stage outputs feed the ALU control, data memory, forwarding unit and write-back mux.

Parameters:
- ALUOP_W, 2, width of ALUOp; must be >=2; 2-bit codes are zero-extended.
- ENABLE_JAL, 1, 1 decodes JAL (1101111); 0 treats it as illegal.
- HAZARD_EN, 1, 1 enables internal load-use detection; 0 forces stall_o=0.
- CNT_W, 16, width of the bubble counter.

Ports:
- clk_i input 1: clock, rising edge.
- rst_i input 1: synchronous active-high reset.
- valid_i input 1: the ID-stage instruction is valid.
- op_i input 7: ID-stage opcode.
- rs1_i input 5: ID-stage rs1.
- rs2_i input 5: ID-stage rs2.
- rd_i input 5: ID-stage rd.
- flush_i input 1: taken branch/jump; insert a bubble into ID/EX.
- stall_i input 1: global freeze (memory wait); all stage registers hold.
- stall_o output 1: load-use stall request to PC and IF/ID (combinational).
- ex_alu_op_o output ALUOP_W: EX-stage ALUOp.
- ex_alu_src_o output 1: EX-stage ALUSrc.
- ex_branch_o output 1: EX-stage Branch.
- ex_jump_o output 1: EX-stage Jump.
- ex_illegal_o output 1: EX-stage illegal-opcode flag.
- ex_rd_o output 5: EX-stage rd.
- mem_mem_read_o output 1: MEM-stage MemRead.
- mem_mem_write_o output 1: MEM-stage MemWrite.
- mem_reg_write_o output 1: MEM-stage RegWrite (for forwarding).
- mem_rd_o output 5: MEM-stage rd.
- wb_reg_write_o output 1: WB-stage RegWrite.
- wb_mem_to_reg_o output 1: WB-stage MemtoReg.
- wb_rd_o output 5: WB-stage rd.
- bubble_cnt_o output CNT_W: count of bubbles inserted.

Behaviour:
- Decode (combinational, ID stage). Fields are RegWrite, MemtoReg, MemRead, MemWrite, ALUOp, ALUSrc, Branch, Jump:
  - 0110011 R-type: 1,0,0,0,10,0,0,0.
  - 0010011 I-ALU: 1,0,0,0,11,1,0,0.
  - 0000011 lw: 1,1,1,0,00,1,0,0.
  - 0100011 sw: 0,0,0,1,00,1,0,0.
  - 1100011 beq: 0,0,0,0,01,0,1,0.
  - 1101111 jal (ENABLE_JAL=1): 1,0,0,0,00,0,0,1.
  - Any other opcode, or valid_i=0: all fields 0 and rd=0. illegal=1 only when valid_i=1 and the opcode is undecoded.
- rs2 is used only for R-type, sw and beq. rs1 is used by every decoded opcode except jal.
- Load-use hazard, stall_o=1 when all of the following hold:
  - HAZARD_EN=1 and valid_i=1;
  - the ID/EX register holds MemRead=1 with ex_rd_o!=0;
  - ex_rd_o equals a used source register (rs1_i and/or rs2_i per the rule above).
- ID/EX update priority per rising edge:
  - rst_i: clear.
  - else stall_i: hold.
  - else flush_i or stall_o: load a bubble (all control 0, rd 0, illegal 0).
  - else load the decoded bundle.
- EX/MEM and MEM/WB update: rst_i clears; else stall_i holds; else shift from the previous stage. A bubble in ID/EX never blocks downstream shifting.
- Latency: an instruction decoded in cycle N shows on ex_* at N+1, mem_* at N+2 and wb_* at N+3, absent stalls.
- Reset: every registered output is 0, bubble_cnt_o=0, and stall_o=0 because ID/EX is cleared.
- Simultaneous flush_i and stall_o: one bubble, counted once.
- stall_i with flush_i: stall_i wins; flush_i is ignored in that cycle. The front end must hold flush_i until stall_i drops.
- bubble_cnt_o increments by 1 on each edge that loads a bubble while rst_i=0 and stall_i=0. It saturates at all-ones with no wrap.
- Reset mid-operation: all in-flight control is discarded on the edge after rst_i is sampled high, and the counter clears.
- Write to x0: rd=0 entries are carried as-is. Hazard logic ignores rd=0.

Test Plan:
- Reset, then R-type (op 0110011, rd=5): ex_alu_op_o=10 at N+1, mem_reg_write_o=1 and mem_rd_o=5 at N+2, wb_reg_write_o=1 and wb_rd_o=5 at N+3.
- lw rd=3 followed by add rs1=3: stall_o=1 for exactly one cycle; the ID/EX bubble shows ex_alu_op_o=0 and ex_rd_o=0; bubble_cnt_o=1; the add appears at EX one cycle later.
- lw rd=0 followed by add rs1=0: stall_o stays 0 and no bubble is inserted. lw rd=4 followed by jal (rs1 field=4): no stall.
- beq, then flush_i=1 with stall_i=1 for 2 cycles: all stage outputs hold. When stall_i falls with flush_i still 1: one bubble is loaded and bubble_cnt_o increments by 1.
- op 1111111 with valid_i=1: ex_illegal_o=1 and all other control 0. The same opcode with valid_i=0: ex_illegal_o=0. jal with ENABLE_JAL=0: ex_illegal_o=1.
- CNT_W=2, 5 consecutive flushes: bubble_cnt_o reads 1,2,3,3,3. Assert rst_i mid-sequence: all outputs are 0 on the next edge.
